// File: rtl/apb_csr_master.sv
// APB requester for the ALU CSR slave; optional watchdog under APB_CSR_MASTER_TIMEOUT_EN.
// Latency: SETUP one cycle after accept, response pulse 3+k cycles after accept (k = slave waits).
// Backpressure: cmd_ready only in IDLE, including the response cycle; one command in flight.
module apb_csr_master #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  output logic                  apb_sel,
  output logic                  apb_en,
  output logic                  apb_write,
  output logic [DATA_WIDTH-1:0] apb_wdata,
  input  logic                  apb_ready,
  input  logic [DATA_WIDTH-1:0] apb_rdata,
  input  logic                  apb_slv_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_csr_master: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t state;

  // Returning to IDLE together with the response lets a new command overlap rsp_valid.
  assign cmd_ready = (state == S_IDLE);

`ifdef APB_CSR_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] acc_cnt;
  logic             timeout_q;

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      apb_sel   <= 1'b0;
      apb_en    <= 1'b0;
      apb_write <= 1'b0;
      apb_addr  <= '0;
      apb_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_CSR_MASTER_TIMEOUT_EN
      acc_cnt   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef APB_CSR_MASTER_TIMEOUT_EN
          acc_cnt <= '0;
`endif
          if (cmd_valid) begin
            apb_write <= cmd_write;
            apb_addr  <= cmd_addr;
            apb_wdata <= cmd_wdata;
            apb_sel   <= 1'b1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          apb_en <= 1'b1;
          state  <= S_ACCESS;
`ifdef APB_CSR_MASTER_TIMEOUT_EN
          acc_cnt <= CNT_W'(1);
`endif
        end
        S_ACCESS: begin
          if (apb_ready) begin
            apb_sel   <= 1'b0;
            apb_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= apb_slv_err;
            rsp_rdata <= apb_write ? '0 : apb_rdata;
`ifdef APB_CSR_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            state     <= S_IDLE;
          end
`ifdef APB_CSR_MASTER_TIMEOUT_EN
          // A ready slave in the last allowed cycle still wins over the abort.
          else if (acc_cnt == CNT_LAST) begin
            apb_sel   <= 1'b0;
            apb_en    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            timeout_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            acc_cnt <= acc_cnt + 1'b1;
          end
`endif
        end
        default: begin
          apb_sel <= 1'b0;
          apb_en  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_csr_master.sv
// Scoreboard bench for apb_csr_master: directed commands, reactive APB slave, decoupled monitor.
module tb_apb_csr_master;

  localparam int AW  = 3;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] apb_addr;
  logic          apb_sel;
  logic          apb_en;
  logic          apb_write;
  logic [DW-1:0] apb_wdata;
  logic          apb_ready;
  logic [DW-1:0] apb_rdata;
  logic          apb_slv_err;

  apb_csr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
    .apb_wdata(apb_wdata), .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slv_err(apb_slv_err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic        never;
  } apb_exp_t;

  rsp_exp_t rsp_q[$];
  apb_exp_t apb_q[$];
  apb_exp_t cur;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;
  logic        last_tmo   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor, scoreboard and reactive slave share one negedge process.
  initial begin
    logic prev_sel;
    int   acc_cnt;
    rsp_exp_t e;
    prev_sel    = 1'b0;
    acc_cnt     = 0;
    apb_ready   = 1'b0;
    apb_rdata   = 32'hDEAD_BEEF;
    apb_slv_err = 1'b0;
    cur         = '{cyc: 0, addr: 3'd0, wr: 1'b0, wdata: 32'd0, waits: 0, rdata: 32'd0, err: 1'b0, never: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        apb_ready = 1'b0;
        prev_sel  = 1'b0;
        acc_cnt   = 0;
      end else begin
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding command (cycle %0d)", cyc);
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
            last_rdata = e.rdata;
            last_err   = e.err;
            last_tmo   = e.tmo;
          end
        end else begin
          chk("hold_rdata", rsp_rdata, last_rdata);
          chk("hold_err", {31'd0, rsp_err}, {31'd0, last_err});
          chk("hold_timeout", {31'd0, rsp_timeout}, {31'd0, last_tmo});
        end

        if (apb_sel && !apb_en) begin
          chk("sel_gap", {31'd0, prev_sel}, 32'd0);
          if (apb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_setup: apb_sel rose with no command (cycle %0d)", cyc);
          end else begin
            cur = apb_q.pop_front();
            chk("setup_cycle", cyc, cur.cyc);
            chk("setup_addr", {29'd0, apb_addr}, {29'd0, cur.addr});
            chk("setup_write", {31'd0, apb_write}, {31'd0, cur.wr});
            chk("setup_wdata", apb_wdata, cur.wdata);
          end
          acc_cnt = 0;
        end else if (apb_sel && apb_en) begin
          chk("access_after_sel", {31'd0, prev_sel}, 32'd1);
          chk("access_addr", {29'd0, apb_addr}, {29'd0, cur.addr});
          chk("access_write", {31'd0, apb_write}, {31'd0, cur.wr});
          chk("access_wdata", apb_wdata, cur.wdata);
        end else begin
          chk("en_without_sel", {31'd0, apb_en}, 32'd0);
        end

        if (apb_sel && apb_en) begin
          if (!cur.never && acc_cnt >= cur.waits) begin
            apb_ready   = 1'b1;
            apb_rdata   = cur.rdata;
            apb_slv_err = cur.err;
          end else begin
            apb_ready   = 1'b0;
            apb_rdata   = 32'hDEAD_BEEF;
            apb_slv_err = 1'b1;
          end
          acc_cnt++;
        end else begin
          apb_ready   = 1'b0;
          apb_rdata   = 32'hDEAD_BEEF;
          apb_slv_err = 1'b0;
        end
        prev_sel = apb_sel;
      end
    end
  end

  // mode 0: normal response, 1: slave never ready and no response, 2: watchdog abort
  task automatic send(input logic w, input logic [2:0] a, input logic [31:0] d, input int waits,
                      input logic [31:0] rd, input logic er, input int mode, output int acc);
    int t;
    rsp_exp_t re;
    apb_exp_t ae;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept: cmd_ready stuck low for 50 cycles (cycle %0d)", cyc);
    end
    acc = cyc + 1;
    ae = '{cyc: acc, addr: a, wr: w, wdata: d, waits: waits, rdata: rd, err: er, never: (mode != 0)};
    apb_q.push_back(ae);
    if (mode == 0) begin
      re = '{cyc: acc + 2 + waits, rdata: (w ? 32'd0 : rd), err: er, tmo: 1'b0};
      rsp_q.push_back(re);
    end else if (mode == 2) begin
      re = '{cyc: acc + 2 + (TMO - 1), rdata: 32'd0, err: 1'b1, tmo: 1'b1};
      rsp_q.push_back(re);
    end
    @(posedge clk);
  endtask

  task automatic idle_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d responses still outstanding after 200 cycles", rsp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0, a1, a2, t;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_apb_sel", {31'd0, apb_sel}, 32'd0);
    chk("reset_apb_en", {31'd0, apb_en}, 32'd0);
    chk("reset_apb_addr", {29'd0, apb_addr}, 32'd0);
    chk("reset_apb_write", {31'd0, apb_write}, 32'd0);
    chk("reset_apb_wdata", apb_wdata, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);

    // Single transfers: zero-wait write, waited read, errored read, errored write with waits.
    send(1'b1, 3'd1, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0, 0, a0);
    idle_cmd();
    drain();
    send(1'b0, 3'd3, 32'h0000_1111, 1, 32'h0012_3456, 1'b0, 0, a0);
    idle_cmd();
    drain();
    send(1'b0, 3'd0, 32'h0, 0, 32'h0, 1'b1, 0, a0);
    idle_cmd();
    drain();
    send(1'b1, 3'd4, 32'h5A5A_0000, 2, 32'h7777_7777, 1'b1, 0, a0);
    idle_cmd();
    drain();

    // Back-to-back with cmd_valid held high: 3-cycle cadence.
    send(1'b1, 3'd2, 32'hC0DE_0001, 0, 32'h0, 1'b0, 0, a0);
    send(1'b0, 3'd4, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 0, a1);
    send(1'b1, 3'd3, 32'hC0DE_0003, 0, 32'h0, 1'b0, 0, a2);
    idle_cmd();
    chk("cadence_1_2", a1 - a0, 32'd3);
    chk("cadence_2_3", a2 - a1, 32'd3);
    drain();

    // Slave never ready, then reset in the middle of ACCESS.
    send(1'b0, 3'd2, 32'h0, 0, 32'h0, 1'b0, 1, a0);
    idle_cmd();
    t = 0;
    while (!(apb_sel && apb_en) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reached_access", {30'd0, apb_sel, apb_en}, 32'd3);
`ifndef APB_CSR_MASTER_TIMEOUT_EN
    repeat (100) @(negedge clk);
    chk("access_persists", {30'd0, apb_sel, apb_en}, 32'd3);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_apb_sel", {31'd0, apb_sel}, 32'd0);
    chk("arst_apb_en", {31'd0, apb_en}, 32'd0);
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    last_rdata = '0;
    last_err   = 1'b0;
    last_tmo   = 1'b0;
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_reset_apb_sel", {31'd0, apb_sel}, 32'd0);

`ifdef APB_CSR_MASTER_TIMEOUT_EN
    send(1'b0, 3'd4, 32'h0, 0, 32'h1234_5678, 1'b0, 2, a0);
    idle_cmd();
    drain();
`endif

    // Normal operation resumes after the reset.
    send(1'b0, 3'd1, 32'h0, 0, 32'h8000_0001, 1'b0, 0, a0);
    idle_cmd();
    drain();

    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    chk("apb_queue_empty", apb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "tb_apb_csr_master timed out");
  end

endmodule
